ifm_stream_feeder: RTL and testbench



---
 rtl/ifm_stream_feeder_if.sv | 39 +++
 rtl/ifm_stream_feeder.sv | 179 +++++++++++++++++
 tb/tb_ifm_stream_feeder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ifm_stream_feeder_if.sv
// Bundle of the feeder's control, BRAM read port and output pixel stream signals.
// The master modport is the feeder; the slave modport is its environment.
interface ifm_stream_feeder_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [2:0]        sel;
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [63:0]       rd_data;
    logic [7:0]        ifmstream_0;
    logic [7:0]        ifmstream_1;
    logic [7:0]        ifmstream_2;
    logic [7:0]        ifmstream_3;
    logic [7:0]        ifmstream_4;
    logic [7:0]        ifmstream_5;
    logic [7:0]        ifmstream_6;
    logic [7:0]        ifmstream_7;
    logic              stream_valid;
    logic              frame_last;

    modport master (
        input  sel, start, rd_data,
        output busy, done, rd_en, rd_addr,
        output ifmstream_0, ifmstream_1, ifmstream_2, ifmstream_3,
        output ifmstream_4, ifmstream_5, ifmstream_6, ifmstream_7,
        output stream_valid, frame_last
    );

    modport slave (
        output sel, start, rd_data,
        input  busy, done, rd_en, rd_addr,
        input  ifmstream_0, ifmstream_1, ifmstream_2, ifmstream_3,
        input  ifmstream_4, ifmstream_5, ifmstream_6, ifmstream_7,
        input  stream_valid, frame_last
    );
endinterface

// File: rtl/ifm_stream_feeder.sv
// Raster-order feeder: walks a zero-padded (W+2)x(W+2) frame, reads interior pixels from BRAM
// and emits eight parallel 8-bit channel streams, one pixel per cycle.
module ifm_stream_feeder #(
    parameter int unsigned LEN1   = 16,
    parameter int unsigned LEN2   = 14,
    parameter int unsigned LEN3   = 28,
    parameter int unsigned LEN4   = 56,
    parameter int unsigned LEN5   = 112,
    parameter int unsigned LEN6   = 224,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_LAT = 2
) (
    input logic                clk,
    input logic                rst,
    ifm_stream_feeder_if.master bus
);
    // Wide enough to hold W+1 for the largest row width.
    localparam int unsigned CntW = $clog2(LEN6 + 2);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]   width_q;
    logic [CntW-1:0]   row_q;
    logic [CntW-1:0]   col_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        drain_q;
    logic              done_q;

    logic [RD_LAT-1:0] valid_pipe_q;
    logic [RD_LAT-1:0] border_pipe_q;
    logic [RD_LAT-1:0] last_pipe_q;

    logic [63:0]       pix_q;
    logic              stream_valid_q;
    logic              frame_last_q;

    logic [CntW-1:0]   sel_len;
    logic              sel_ok;
    logic              start_acc;
    logic [CntW-1:0]   edge_idx;
    logic              col_last;
    logic              row_last;
    logic              issue_valid;
    logic              issue_border;
    logic              issue_last;
    logic              issue_read;
    logic              drain_end;

    always_comb begin
        sel_ok  = 1'b1;
        sel_len = '0;
        case (bus.sel)
            3'd0:    sel_len = CntW'(LEN1);
            3'd1:    sel_len = CntW'(LEN2);
            3'd2:    sel_len = CntW'(LEN3);
            3'd3:    sel_len = CntW'(LEN4);
            3'd4:    sel_len = CntW'(LEN5);
            3'd5:    sel_len = CntW'(LEN6);
            default: sel_ok  = 1'b0;
        endcase
    end

    assign start_acc = (state_q == StIdle) && bus.start && sel_ok;
    assign edge_idx  = width_q + CntW'(1);
    assign col_last  = (col_q == edge_idx);
    assign row_last  = (row_q == edge_idx);
    assign drain_end = (drain_q == 3'(RD_LAT));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_acc) state_d = StRun;
            StRun:   if (issue_last) state_d = StDrain;
            StDrain: if (drain_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / issue-stage decode
    always_comb begin
        issue_valid  = (state_q == StRun);
        issue_border = (row_q == '0) || row_last || (col_q == '0) || col_last;
        issue_last   = issue_valid && row_last && col_last;
        issue_read   = issue_valid && !issue_border;
    end

    // Row/column walk and the sequential read address; the address only advances on interior
    // pixels, so it stays put across border cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q  <= (state_q == StDrain) && drain_end;
            drain_q <= (state_q == StDrain) ? drain_q + 3'd1 : 3'd0;
            if (start_acc) begin
                width_q <= sel_len;
                row_q   <= '0;
                col_q   <= '0;
                addr_q  <= '0;
            end else if (issue_valid) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_q + CntW'(1);
                end else begin
                    col_q <= col_q + CntW'(1);
                end
                if (issue_read) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
        end
    end

    // Tags ride alongside the BRAM read so they line up with rd_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe_q  <= '0;
            border_pipe_q <= '0;
            last_pipe_q   <= '0;
        end else begin
            valid_pipe_q[0]  <= issue_valid;
            border_pipe_q[0] <= issue_border;
            last_pipe_q[0]   <= issue_last;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                valid_pipe_q[i]  <= valid_pipe_q[i-1];
                border_pipe_q[i] <= border_pipe_q[i-1];
                last_pipe_q[i]   <= last_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q          <= '0;
            stream_valid_q <= 1'b0;
            frame_last_q   <= 1'b0;
        end else begin
            stream_valid_q <= valid_pipe_q[RD_LAT-1];
            frame_last_q   <= valid_pipe_q[RD_LAT-1] && last_pipe_q[RD_LAT-1];
            if (valid_pipe_q[RD_LAT-1] && !border_pipe_q[RD_LAT-1]) begin
                pix_q <= bus.rd_data;
            end else begin
                pix_q <= '0;
            end
        end
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = done_q;
    assign bus.rd_en        = issue_read;
    assign bus.rd_addr      = addr_q;
    assign bus.stream_valid = stream_valid_q;
    assign bus.frame_last   = frame_last_q;
    assign bus.ifmstream_0  = pix_q[7:0];
    assign bus.ifmstream_1  = pix_q[15:8];
    assign bus.ifmstream_2  = pix_q[23:16];
    assign bus.ifmstream_3  = pix_q[31:24];
    assign bus.ifmstream_4  = pix_q[39:32];
    assign bus.ifmstream_5  = pix_q[47:40];
    assign bus.ifmstream_6  = pix_q[55:48];
    assign bus.ifmstream_7  = pix_q[63:56];
endmodule

// File: tb/tb_ifm_stream_feeder.sv
// Directed bench for ifm_stream_feeder: a frame table driven through a BRAM model,
// plus hand sequences for reset behaviour and reset in mid-frame.
module tb_ifm_stream_feeder;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned RD_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifm_stream_feeder_if #(.ADDR_W(ADDR_W)) bus ();

    ifm_stream_feeder #(
        .LEN1(16), .LEN2(14), .LEN3(28), .LEN4(56), .LEN5(112), .LEN6(224),
        .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit mode = 1'b0;  // 0: word = address byte replicated, 1: word = channel index per byte

    logic [63:0] pix_out;
    assign pix_out = {bus.ifmstream_7, bus.ifmstream_6, bus.ifmstream_5, bus.ifmstream_4,
                      bus.ifmstream_3, bus.ifmstream_2, bus.ifmstream_1, bus.ifmstream_0};

    // Two-cycle read latency BRAM model.
    logic [63:0] bram_s1 = '0;
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bram_s1 <= mode ? 64'h0706050403020100 : {8{bus.rd_addr[7:0]}};
        end
        bus.rd_data <= bram_s1;
    end

    typedef struct {
        logic [2:0] sel;
        bit         mode;
        int         w;
        int         npix;
        int         nreads;
        bit         mid_start;
        bit         chain;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_pixel(input int w, input int p, input bit m);
        int r;
        int c;
        int a;
        r = p / (w + 2);
        c = p % (w + 2);
        if (r == 0 || r == w + 1 || c == 0 || c == w + 1) return 64'h0;
        if (m) return 64'h0706050403020100;
        a = (r - 1) * w + (c - 1);
        return {8{a[7:0]}};
    endfunction

    task automatic run_frame(input vec_t v, input bit pre, input bit chain,
                             input logic [2:0] nsel, input bit nmode);
        int cyc;
        int p;
        int nrd;
        bit finished;
        bit done_early;
        p = 0;
        nrd = 0;
        finished = 1'b0;
        done_early = 1'b0;
        if (!pre) begin
            @(negedge clk);
            mode = v.mode;
            bus.sel = v.sel;
            bus.start = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.sel = 3'd6;
        cyc = 1;
        check("busy_after_start", 64'(bus.busy), 64'(v.npix > 0));
        while (!finished) begin
            if (bus.done && (bus.stream_valid || p == 0)) done_early = 1'b1;
            if (bus.rd_en) begin
                check("rd_addr", 64'(bus.rd_addr), 64'(nrd));
                nrd++;
            end
            if (bus.stream_valid) begin
                if (p == 0) check("first_valid_edge", 64'(cyc - 1), 64'(RD_LAT + 1));
                if (p < v.npix) check("pixel", pix_out, exp_pixel(v.w, p, v.mode));
                check("frame_last", 64'(bus.frame_last), 64'(p == v.npix - 1));
                p++;
            end else if (p > 0) begin
                check("done_pulse", 64'(bus.done), 64'd1);
                check("busy_at_done", 64'(bus.busy), 64'd0);
                if (chain) begin
                    mode = nmode;
                    bus.sel = nsel;
                    bus.start = 1'b1;
                end
                finished = 1'b1;
            end
            if (!finished) begin
                if (v.mid_start && cyc == 50) begin
                    bus.start = 1'b1;
                    bus.sel = 3'd5;
                end else if (v.mid_start && cyc == 51) begin
                    bus.start = 1'b0;
                    bus.sel = 3'd6;
                end
                if (v.npix == 0 && cyc == 12) begin
                    finished = 1'b1;
                end else if (cyc > v.npix + 20) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_timeout: no end after %0d cycles, expected %0d pixels",
                             cyc, v.npix);
                    finished = 1'b1;
                end else begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        check("pixel_count", 64'(p), 64'(v.npix));
        check("read_count", 64'(nrd), 64'(v.nreads));
        check("no_early_done", 64'(done_early), 64'd0);
    endtask

    initial begin
        vec_t nv;
        vec_t v3;
        bit pre;
        int p;
        bit seen_done;

        vecs[0] = '{3'd6, 1'b0, 0,   0,     0,     1'b0, 1'b0};
        vecs[1] = '{3'd7, 1'b0, 0,   0,     0,     1'b0, 1'b0};
        vecs[2] = '{3'd1, 1'b0, 14,  256,   196,   1'b0, 1'b0};
        vecs[3] = '{3'd0, 1'b1, 16,  324,   256,   1'b0, 1'b1};
        vecs[4] = '{3'd2, 1'b0, 28,  900,   784,   1'b0, 1'b0};
        vecs[5] = '{3'd0, 1'b0, 16,  324,   256,   1'b1, 1'b0};
        vecs[6] = '{3'd4, 1'b0, 112, 12996, 12544, 1'b0, 1'b0};
        v3      = '{3'd3, 1'b0, 56,  3364,  3136,  1'b0, 1'b0};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.sel = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_rd_en", 64'(bus.rd_en), 64'd0);
        check("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        check("rst_stream_valid", 64'(bus.stream_valid), 64'd0);
        check("rst_frame_last", 64'(bus.frame_last), 64'd0);
        check("rst_streams", pix_out, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            pre = 1'b0;
            if (i > 0) pre = vecs[i-1].chain;
            nv = (i < 6) ? vecs[i+1] : vecs[i];
            run_frame(vecs[i], pre, vecs[i].chain, nv.sel, nv.mode);
        end

        // Reset while pixel 100 of a sel=3 frame is on the outputs.
        @(negedge clk);
        mode = 1'b0;
        bus.sel = 3'd3;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        p = 0;
        for (int c = 0; c < 200 && p < 101; c++) begin
            if (bus.stream_valid) p++;
            if (p < 101) @(negedge clk);
        end
        check("reached_pixel_100", 64'(p), 64'd101);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 64'(bus.stream_valid), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        seen_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.done || bus.stream_valid) seen_done = 1'b1;
            @(negedge clk);
        end
        check("mid_rst_no_done", 64'(seen_done), 64'd0);
        run_frame(v3, 1'b0, 1'b0, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
